// File: rtl/scomp_pkg.sv
// Shared definitions for the parametrised accumulator processor: opcodes,
// FSM state encoding and the opcode-to-execute-state decode.
package scomp_pkg;

    localparam int OPC_W   = 4;
    localparam int SHAMT_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OPC_W-1:0] OP_ST    = 4'h1;
    localparam logic [OPC_W-1:0] OP_LD    = 4'h2;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'h3;
    localparam logic [OPC_W-1:0] OP_JNEG  = 4'h4;
    localparam logic [OPC_W-1:0] OP_OUT   = 4'h5;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'h6;
    localparam logic [OPC_W-1:0] OP_AND   = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZERO = 4'h8;
    localparam logic [OPC_W-1:0] OP_LDI   = 4'h9;
    localparam logic [OPC_W-1:0] OP_SHL   = 4'hA;
    localparam logic [OPC_W-1:0] OP_SHR   = 4'hB;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'hC;

    typedef enum logic [3:0] {
        S_RESET_PC  = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EX_ADD    = 4'd3,
        S_EX_SUB    = 4'd4,
        S_EX_AND    = 4'd5,
        S_EX_LOAD   = 4'd6,
        S_EX_STORE  = 4'd7,
        S_EX_STORE2 = 4'd8,
        S_EX_JUMP   = 4'd9,
        S_EX_JNEG   = 4'd10,
        S_EX_JZERO  = 4'd11,
        S_EX_LDI    = 4'd12,
        S_EX_SHIFT  = 4'd13,
        S_EX_OUT    = 4'd14,
        S_HALT      = 4'd15
    } state_t;

    // opc_valid is low when any opcode bit above the low nibble is set.
    function automatic state_t decode_state(input logic [OPC_W-1:0] opc,
                                            input logic opc_valid);
        state_t s;
        s = S_FETCH;
        if (opc_valid) begin
            case (opc)
                OP_ADD:         s = S_EX_ADD;
                OP_ST:          s = S_EX_STORE;
                OP_LD:          s = S_EX_LOAD;
                OP_JMP:         s = S_EX_JUMP;
                OP_JNEG:        s = S_EX_JNEG;
                OP_OUT:         s = S_EX_OUT;
                OP_SUB:         s = S_EX_SUB;
                OP_AND:         s = S_EX_AND;
                OP_JZERO:       s = S_EX_JZERO;
                OP_LDI:         s = S_EX_LDI;
                OP_SHL, OP_SHR: s = S_EX_SHIFT;
                OP_HALT:        s = S_HALT;
                default:        s = S_FETCH;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/scomp_ram.sv
// Single-port program/data RAM: registered address, write on the clock edge,
// unregistered read of the word addressed in the previous cycle.
module scomp_ram #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = "program.mif"
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        addr_q <= addr;
    end

    assign rdata = mem[addr_q];

endmodule

// File: rtl/scomp_param.sv
// Parametrised accumulator processor executing a program held in scomp_ram.
//
//  state       | meaning
//  RESET_PC    | present address 0 for the first fetch
//  FETCH       | IR <- mem[PC], PC <- PC + 1
//  DECODE      | present operand address, branch on opcode
//  EX_ADD/SUB  | A <- A +/- mem[op]
//  EX_AND      | A <- A & mem[op]
//  EX_LOAD     | A <- mem[op]
//  EX_STORE    | write A to mem[op]
//  EX_STORE2   | re-present PC after the write
//  EX_JUMP     | PC <- op
//  EX_JNEG     | PC <- op when A is negative
//  EX_JZERO    | PC <- op when A is zero
//  EX_LDI      | A <- zero-extended op
//  EX_SHIFT    | A shifted left/right by op[3:0]
//  EX_OUT      | out <- A, pulse out_valid
//  HALT        | frozen until reset
module scomp_param
    import scomp_pkg::*;
#(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = "program.mif"
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] program_counter,
    output logic [DATA_W-1:0] register_A,
    output logic [DATA_W-1:0] instruction_register,
    output logic [DATA_W-1:0] memory_data_register_out,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              halted
);

    state_t              state;
    state_t              state_nxt;
    state_t              decode_nxt;

    logic [ADDR_W-1:0]   pc_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   ir_q;
    logic [DATA_W-1:0]   out_q;
    logic                out_valid_q;

    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    logic [ADDR_W-1:0]   operand;
    logic [OPC_W-1:0]    opc_lo;
    logic                opc_valid;
    logic [SHAMT_W-1:0]  shamt;
    logic                a_neg;
    logic                a_zero;

    assign operand    = ir_q[ADDR_W-1:0];
    assign opc_lo     = ir_q[ADDR_W +: OPC_W];
    assign opc_valid  = ((ir_q >> (ADDR_W + OPC_W)) == '0);
    assign shamt      = operand[SHAMT_W-1:0];
    assign a_neg      = a_q[DATA_W-1];
    assign a_zero     = (a_q == '0);
    assign decode_nxt = decode_state(opc_lo, opc_valid);

    scomp_ram #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(a_q),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_RESET_PC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_addr  = pc_q;
        ram_we    = 1'b0;
        case (state)
            S_RESET_PC: begin
                ram_addr  = '0;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = decode_nxt;
                // A NOP returns straight to FETCH, which needs mem[PC] next.
                ram_addr  = (decode_nxt == S_FETCH) ? pc_q : operand;
            end
            S_EX_STORE: begin
                ram_addr  = operand;
                ram_we    = 1'b1;
                state_nxt = S_EX_STORE2;
            end
            S_EX_JUMP: begin
                ram_addr  = operand;
                state_nxt = S_FETCH;
            end
            S_EX_JNEG: begin
                if (a_neg) begin
                    ram_addr = operand;
                end
                state_nxt = S_FETCH;
            end
            S_EX_JZERO: begin
                if (a_zero) begin
                    ram_addr = operand;
                end
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            a_q         <= '0;
            ir_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                S_FETCH: begin
                    ir_q <= ram_rdata;
                    pc_q <= pc_q + ADDR_W'(1);
                end
                S_EX_ADD:   a_q <= a_q + ram_rdata;
                S_EX_SUB:   a_q <= a_q - ram_rdata;
                S_EX_AND:   a_q <= a_q & ram_rdata;
                S_EX_LOAD:  a_q <= ram_rdata;
                S_EX_JUMP:  pc_q <= operand;
                S_EX_JNEG: begin
                    if (a_neg) begin
                        pc_q <= operand;
                    end
                end
                S_EX_JZERO: begin
                    if (a_zero) begin
                        pc_q <= operand;
                    end
                end
                S_EX_LDI:   a_q <= {{(DATA_W-ADDR_W){1'b0}}, operand};
                S_EX_SHIFT: a_q <= (opc_lo == OP_SHL) ? (a_q << shamt) : (a_q >> shamt);
                S_EX_OUT: begin
                    out_q       <= a_q;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign program_counter          = pc_q;
    assign register_A               = a_q;
    assign instruction_register     = ir_q;
    assign memory_data_register_out = ram_rdata;
    assign out                      = out_q;
    assign out_valid                = out_valid_q;
    assign halted                   = (state == S_HALT);

endmodule

// File: tb/tb_scomp_param.sv
// Directed bench for scomp_param: programs are preloaded into the RAM array,
// OUT results are checked through an expected-value queue.
module tb_scomp_param;

    logic clock = 1'b0;
    logic reset;
    logic reset2;

    always #5 clock = ~clock;

    logic [7:0]  pc;
    logic [15:0] a, ir, mdr, out;
    logic        out_valid, halted;

    logic [9:0]  pc2;
    logic [23:0] a2, ir2, mdr2, out2;
    logic        out_valid2, halted2;

    scomp_param #(.DATA_W(16), .ADDR_W(8), .INIT_FILE("")) dut (
        .clock                   (clock),
        .reset                   (reset),
        .program_counter         (pc),
        .register_A              (a),
        .instruction_register    (ir),
        .memory_data_register_out(mdr),
        .out                     (out),
        .out_valid               (out_valid),
        .halted                  (halted)
    );

    scomp_param #(.DATA_W(24), .ADDR_W(10), .INIT_FILE("")) dut2 (
        .clock                   (clock),
        .reset                   (reset2),
        .program_counter         (pc2),
        .register_A              (a2),
        .instruction_register    (ir2),
        .memory_data_register_out(mdr2),
        .out                     (out2),
        .out_valid               (out_valid2),
        .halted                  (halted2)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [31:0] sb2[$];
    int k, pulses, pulse_k, halt_k, we_cycles, pulses2, pulse_k2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear16();
        for (int i = 0; i < 256; i++) dut.u_ram.mem[8'(i)] <= '0;
    endtask

    task automatic clear24();
        for (int i = 0; i < 1024; i++) dut2.u_ram.mem[10'(i)] <= '0;
    endtask

    task automatic load16(input logic [7:0] ad, input logic [15:0] w);
        dut.u_ram.mem[ad] <= w;
    endtask

    task automatic load24(input logic [9:0] ad, input logic [23:0] w);
        dut2.u_ram.mem[ad] <= w;
    endtask

    task automatic begin_test();
        reset = 1'b1;
        @(negedge clock);
        clear16();
        sb.delete();
    endtask

    task automatic go16();
        @(negedge clock);
        reset     = 1'b0;
        k         = 0;
        pulses    = 0;
        pulse_k   = -1;
        halt_k    = -1;
        we_cycles = 0;
    endtask

    // Advance n cycles, sampling at the falling edge and scoring OUT pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            k++;
            if (dut.ram_we) we_cycles++;
            if (halted && halt_k < 0) halt_k = k;
            if (out_valid) begin
                pulses++;
                pulse_k = k;
                if (sb.size() == 0) check("out_valid_unexpected", 32'(out_valid), 32'h0);
                else check("out_value", 32'(out), sb.pop_front());
            end
            if (out_valid2) begin
                pulses2++;
                pulse_k2 = k;
                if (sb2.size() == 0) check("out_valid2_unexpected", 32'(out_valid2), 32'h0);
                else check("out2_value", 32'(out2), sb2.pop_front());
            end
        end
    endtask

    task automatic check_reset16(input string p);
        check({p, "_pc"},        32'(pc),        32'h0);
        check({p, "_a"},         32'(a),         32'h0);
        check({p, "_ir"},        32'(ir),        32'h0);
        check({p, "_out"},       32'(out),       32'h0);
        check({p, "_out_valid"}, 32'(out_valid), 32'h0);
        check({p, "_halted"},    32'(halted),    32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        reset2   = 1'b1;
        pulses2  = 0;
        pulse_k2 = -1;
        @(negedge clock);
        clear16();
        clear24();
        check_reset16("rst");

        // LDI 5; OUT; HALT
        load16(8'h00, 16'h0905);
        load16(8'h01, 16'h0500);
        load16(8'h02, 16'h0C00);
        sb.push_back(32'h5);
        go16();
        run(12);
        check("t1_pulse_cycle", 32'(pulse_k), 32'd7);
        check("t1_pulses",      32'(pulses),  32'd1);
        check("t1_halt_cycle",  32'(halt_k),  32'd9);
        check("t1_halted",      32'(halted),  32'h1);
        check("t1_pc",          32'(pc),      32'h3);
        check("t1_a",           32'(a),       32'h5);
        check("t1_out",         32'(out),     32'h5);
        check("t1_ir",          32'(ir),      32'h0C00);

        // overflow into sign bit, JNEG taken, SUB to zero, JZERO taken
        begin_test();
        load16(8'h00, 16'h0210);
        load16(8'h01, 16'h0011);
        load16(8'h02, 16'h0500);
        load16(8'h03, 16'h0408);
        for (int i = 4; i < 8; i++) load16(8'(i), 16'h0C00);
        load16(8'h08, 16'h0612);
        load16(8'h09, 16'h080C);
        load16(8'h0A, 16'h0C00);
        load16(8'h0B, 16'h0C00);
        load16(8'h0C, 16'h0500);
        load16(8'h0D, 16'h0C00);
        load16(8'h0E, 16'hBEEF);
        load16(8'h10, 16'h7FFF);
        load16(8'h11, 16'h0001);
        load16(8'h12, 16'h8000);
        sb.push_back(32'h8000);
        sb.push_back(32'h0000);
        go16();
        run(30);
        check("t2_pulses", 32'(pulses), 32'd2);
        check("t2_halted", 32'(halted), 32'h1);
        check("t2_pc",     32'(pc),     32'h0E);
        check("t2_a",      32'(a),      32'h0);
        check("t2_mdr",    32'(mdr),    32'hBEEF);

        // store then reload, branches not taken
        begin_test();
        load16(8'h00, 16'h09AA);
        load16(8'h01, 16'h0120);
        load16(8'h02, 16'h0900);
        load16(8'h03, 16'h0220);
        load16(8'h04, 16'h0500);
        load16(8'h05, 16'h0430);
        load16(8'h06, 16'h0830);
        load16(8'h07, 16'h0C00);
        load16(8'h30, 16'h0C00);
        sb.push_back(32'h00AA);
        go16();
        run(30);
        check("t3_we_cycles", 32'(we_cycles),           32'd1);
        check("t3_mem20",     32'(dut.u_ram.mem[8'h20]), 32'h00AA);
        check("t3_pc",        32'(pc),                  32'h08);
        check("t3_a",         32'(a),                   32'h00AA);

        // shifts, AND, SUB wrap
        begin_test();
        load16(8'h00, 16'h0981);
        load16(8'h01, 16'h0A04);
        load16(8'h02, 16'h0500);
        load16(8'h03, 16'h0B08);
        load16(8'h04, 16'h0500);
        load16(8'h05, 16'h0901);
        load16(8'h06, 16'h0A0F);
        load16(8'h07, 16'h0500);
        load16(8'h08, 16'h0740);
        load16(8'h09, 16'h0500);
        load16(8'h0A, 16'h0641);
        load16(8'h0B, 16'h0500);
        load16(8'h0C, 16'h0C00);
        load16(8'h40, 16'h7FFF);
        load16(8'h41, 16'h0001);
        sb.push_back(32'h0810);
        sb.push_back(32'h0008);
        sb.push_back(32'h8000);
        sb.push_back(32'h0000);
        sb.push_back(32'hFFFF);
        go16();
        run(46);
        check("t4_pulses", 32'(pulses), 32'd5);
        check("t4_pc",     32'(pc),     32'h0D);
        check("t4_a",      32'(a),      32'hFFFF);

        // JMP to the top word, PC wrap, opcode 0xF0 as a NOP
        begin_test();
        load16(8'h00, 16'h0810);
        load16(8'h01, 16'hF002);
        load16(8'h02, 16'h0500);
        load16(8'h03, 16'h0C00);
        load16(8'h10, 16'h0903);
        load16(8'h11, 16'h03FF);
        load16(8'hFF, 16'h0050);
        load16(8'h50, 16'h0004);
        sb.push_back(32'h7);
        go16();
        run(11);
        check("t5_pc_wrap", 32'(pc), 32'h00);
        check("t5_ir_top",  32'(ir), 32'h0050);
        run(15);
        check("t5_pulse_cycle", 32'(pulse_k), 32'd21);
        check("t5_halted",      32'(halted),  32'h1);
        check("t5_pc",          32'(pc),      32'h04);

        // reset asserted in the middle of a store
        begin_test();
        load16(8'h00, 16'h0955);
        load16(8'h01, 16'h0500);
        load16(8'h02, 16'h0160);
        load16(8'h03, 16'h0C00);
        load16(8'h60, 16'h1234);
        sb.push_back(32'h55);
        go16();
        run(9);
        check("t6_we_in_store", 32'(dut.ram_we), 32'h1);
        check("t6_out_before",  32'(out),        32'h55);
        reset = 1'b1;
        #1;
        check("t6_we_dropped", 32'(dut.ram_we), 32'h0);
        check_reset16("t6");
        @(negedge clock);
        check("t6_word_whole",
              32'((dut.u_ram.mem[8'h60] == 16'h1234) || (dut.u_ram.mem[8'h60] == 16'h0055)),
              32'h1);

        // first scenario on the 24/10 configuration
        load24(10'h000, 24'h002405);
        load24(10'h001, 24'h001400);
        load24(10'h002, 24'h003000);
        load24(10'h003, 24'h00ABCD);
        sb2.push_back(32'h5);
        @(negedge clock);
        reset2 = 1'b0;
        k      = 0;
        run(12);
        check("t7_pulses",      32'(pulses2),  32'd1);
        check("t7_pulse_cycle", 32'(pulse_k2), 32'd7);
        check("t7_halted",      32'(halted2),  32'h1);
        check("t7_pc",          32'(pc2),      32'h3);
        check("t7_a",           32'(a2),       32'h5);
        check("t7_out",         32'(out2),     32'h5);
        check("t7_ir",          32'(ir2),      32'h003000);
        check("t7_mdr",         32'(mdr2),     32'h00ABCD);

        check("sb_drained",  32'(sb.size()),  32'h0);
        check("sb2_drained", 32'(sb2.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
